// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/write-back control
// with a PC, a condition bit, a bounded memory handshake and a retired-instruction counter.
module ctrl_fsm #(
    parameter logic [7:0]  BOOT_ADDR   = 8'h00,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [8:0]  instr_i,
    input  logic        set_i,
    input  logic        mem_ack_i,
    output logic [7:0]  pc_o,
    output logic        ir_en_o,
    output logic [4:0]  alu_op_o,
    output logic        reg_we_o,
    output logic [1:0]  wb_src_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic        cb_o,
    output logic        halted_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [15:0] retired_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU,
        CL_CMP,
        CL_SET,
        CL_LOAD,
        CL_STORE,
        CL_BR,
        CL_BRB,
        CL_HALT,
        CL_NOP
    } cls_t;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;

    // Last wait-counter value before the timeout fires (MEM_TIMEOUT cycles in MEM without ack).
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    cls_t       cls;
    logic [3:0] imm;
    logic [7:0] wait_cnt;

    function automatic cls_t classify(input logic [4:0] op);
        cls_t c;
        c = CL_NOP;
        casez (op)
            5'b00???, 5'b01???,
            5'b11100, 5'b11101,
            5'b11111, 5'b10100: c = CL_ALU;
            5'b10000, 5'b10101: c = CL_CMP;
            5'b110??:           c = CL_SET;
            5'b10010:           c = CL_LOAD;
            5'b10011:           c = CL_STORE;
            5'b11110:           c = CL_BR;
            5'b10110:           c = CL_BRB;
            5'b10001:           c = CL_HALT;
            default:            c = CL_NOP;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cls       <= CL_NOP;
            imm       <= '0;
            wait_cnt  <= '0;
            pc_o      <= BOOT_ADDR;
            ir_en_o   <= 1'b0;
            alu_op_o  <= '0;
            reg_we_o  <= 1'b0;
            wb_src_o  <= WB_ALU;
            mem_rd_o  <= 1'b0;
            mem_wr_o  <= 1'b0;
            cb_o      <= 1'b0;
            halted_o  <= 1'b0;
            err_o     <= 1'b0;
            busy_o    <= 1'b0;
            retired_o <= '0;
        end else begin
            // Single-cycle strobes default low; the transition into their state raises them.
            ir_en_o  <= 1'b0;
            reg_we_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        pc_o    <= BOOT_ADDR;
                        state   <= FETCH;
                        ir_en_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end

                FETCH: begin
                    alu_op_o <= instr_i[8:4];
                    imm      <= instr_i[3:0];
                    cls      <= classify(instr_i[8:4]);
                    state    <= DECODE;
                end

                DECODE: begin
                    case (cls)
                        CL_ALU, CL_CMP: state <= EXEC;
                        CL_SET: begin
                            state    <= WB;
                            reg_we_o <= 1'b1;
                            wb_src_o <= WB_IMM;
                        end
                        CL_LOAD: begin
                            state    <= MEM;
                            mem_rd_o <= 1'b1;
                            wait_cnt <= '0;
                        end
                        CL_STORE: begin
                            state    <= MEM;
                            mem_wr_o <= 1'b1;
                            wait_cnt <= '0;
                        end
                        CL_BR: begin
                            pc_o      <= cb_o ? pc_o + {{4{imm[3]}}, imm} : pc_o + 8'd1;
                            state     <= FETCH;
                            ir_en_o   <= 1'b1;
                            retired_o <= sat_inc(retired_o);
                        end
                        CL_BRB: begin
                            pc_o      <= cb_o ? pc_o - {4'h0, imm} : pc_o + 8'd1;
                            state     <= FETCH;
                            ir_en_o   <= 1'b1;
                            retired_o <= sat_inc(retired_o);
                        end
                        CL_HALT: begin
                            state     <= HALT;
                            halted_o  <= 1'b1;
                            retired_o <= sat_inc(retired_o);
                        end
                        default: begin
                            pc_o      <= pc_o + 8'd1;
                            state     <= FETCH;
                            ir_en_o   <= 1'b1;
                            retired_o <= sat_inc(retired_o);
                        end
                    endcase
                end

                EXEC: begin
                    state <= WB;
                    if (cls == CL_ALU) begin
                        reg_we_o <= 1'b1;
                        wb_src_o <= WB_ALU;
                    end
                end

                WB: begin
                    if (cls == CL_CMP) begin
                        cb_o <= set_i;
                    end
                    pc_o      <= pc_o + 8'd1;
                    state     <= FETCH;
                    ir_en_o   <= 1'b1;
                    retired_o <= sat_inc(retired_o);
                end

                MEM: begin
                    // Ack is tested first so it wins over a timeout expiring in the same cycle.
                    if (mem_ack_i) begin
                        mem_rd_o <= 1'b0;
                        mem_wr_o <= 1'b0;
                        if (cls == CL_LOAD) begin
                            state    <= WB;
                            reg_we_o <= 1'b1;
                            wb_src_o <= WB_MEM;
                        end else begin
                            pc_o      <= pc_o + 8'd1;
                            state     <= FETCH;
                            ir_en_o   <= 1'b1;
                            retired_o <= sat_inc(retired_o);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            mem_rd_o <= 1'b0;
                            mem_wr_o <= 1'b0;
                            err_o    <= 1'b1;
                            halted_o <= 1'b1;
                            state    <= HALT;
                        end
                    end
                end

                HALT: begin
                    state <= HALT;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter BOOT_ADDR, default 8'h00: PC value loaded on reset and on start.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum cycles spent in MEM waiting for mem_ack_i; range 1..255.
REQ-003 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  begin execution from IDLE.
REQ-006 instr_i  in  9  instruction word from instruction memory: [8:4] opcode, [3:0] imm4.
REQ-007 set_i  in  1  ALU condition output, valid one cycle after the compare opcode is presented.
REQ-008 mem_ack_i  in  1  data memory completion for the current read or write.
REQ-009 pc_o  out  8  instruction address.
REQ-010 ir_en_o  out  1  instruction register load strobe.
REQ-011 alu_op_o  out  5  opcode presented to the ALU.
REQ-012 reg_we_o  out  1  register file write strobe.
REQ-013 wb_src_o  out  2  write-back source: 0 = ALU, 1 = memory, 2 = immediate.
REQ-014 mem_rd_o, mem_wr_o  out  1 each  data memory request.
REQ-015 cb_o  out  1  condition bit.
REQ-016 halted_o, err_o, busy_o  out  1 each  halt, timeout error, not-IDLE.
REQ-017 retired_o  out  16  retired-instruction count.

Function
REQ-018 The block SHALL use these states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Only one state is active at a time.
REQ-019 IDLE: when start_i=1, the block SHALL load pc=BOOT_ADDR and go to FETCH; otherwise it stays in IDLE.
REQ-020 FETCH: ir_en_o=1 for exactly one cycle, and the IR latches instr_i; the next state is DECODE.
REQ-021 DECODE: alu_op_o SHALL equal IR[8:4] from DECODE through WB. The next state depends on the opcode:
- ALU ops (00xxx, 01xxx, 11100, 11101, 11111, 10100) and compares (10000, 10101): go to EXEC.
- set (110xx): go to WB.
- load (10010) and store (10011): go to MEM.
- branch (11110): if cb_o=1, pc = pc + sign-extended imm4, else pc + 1; go to FETCH.
- branchb (10110): if cb_o=1, pc = pc - zero-extended imm4, else pc + 1; go to FETCH.
- halt (10001): go to HALT.
- reserved (10111): treated as a nop; pc + 1; go to FETCH.
REQ-022 EXEC SHALL last exactly one cycle (the ALU is registered); the next state is WB.
REQ-023 WB, one cycle:
- ALU ops: reg_we_o=1, wb_src_o=0.
- set: reg_we_o=1, wb_src_o=2.
- load: reg_we_o=1, wb_src_o=1.
- compares: reg_we_o=0, and cb_o latches set_i.
- All cases: pc = pc + 1; next state is FETCH.
REQ-024 MEM:
- mem_rd_o (load) or mem_wr_o (store) SHALL be held at 1 until the cycle in which mem_ack_i=1.
- On ack, load goes to WB; store does pc + 1 and goes to FETCH. The request deasserts on the cycle after ack.
REQ-025 MEM timeout:
- A wait counter SHALL clear on entry to MEM and increment on each cycle in MEM without ack.
- When the counter reaches MEM_TIMEOUT, err_o is set (sticky), the request deasserts, and the next state is HALT.
- If mem_ack_i=1 in the same cycle the timeout expires, the ack wins.
REQ-026 HALT: halted_o=1 and all strobes are 0. The block leaves HALT only on rst_i.
REQ-027 PC arithmetic SHALL be 8-bit modulo: 8'hFF + 1 wraps to 8'h00, and branches wrap the same way.
REQ-028 retired_o SHALL increment by 1 on each transition into FETCH from DECODE, WB or MEM, and on entry to HALT via halt opcode. It saturates at 16'hFFFF. A timeout entry into HALT does not count.
REQ-029 busy_o=1 in every state except IDLE.
REQ-030 ir_en_o, reg_we_o, mem_rd_o and mem_wr_o SHALL be registered state outputs and never glitch combinationally from inputs.

Reset
REQ-031 When rst_i=1 at a rising edge, the next state SHALL be IDLE from any state, including mid-handshake in MEM.
REQ-032 Reset values: pc_o=BOOT_ADDR, alu_op_o=0, wb_src_o=0, cb_o=0, retired_o=0, wait counter=0. All strobes, halted_o, err_o and busy_o are 0.
REQ-033 Reset SHALL take priority over start_i, mem_ack_i and the timeout.

Verification
REQ-034 add (01000) at pc 0x05 -> states FETCH, DECODE, EXEC, WB; reg_we_o=1 with wb_src_o=0 in cycle 4; pc=0x06; retired_o +1.
REQ-035 seq (10101) with set_i=1, then branch imm4=4'hE at pc 0x10 -> cb_o=1; next pc_o=0x0E. Repeat with cb_o=0 -> pc_o=0x11.
REQ-036 load with mem_ack_i delayed 3 cycles -> mem_rd_o high for 4 cycles; then WB with wb_src_o=1; err_o=0.
REQ-037 store with no ack, MEM_TIMEOUT=15 -> after 15 wait cycles err_o=1, halted_o=1, mem_wr_o=0; retired_o unchanged.
REQ-038 rst_i asserted during a MEM wait -> next cycle IDLE; mem_rd_o=0; pc_o=BOOT_ADDR; start_i then fetches from BOOT_ADDR.
REQ-039 set opcode at pc 8'hFF -> reg_we_o=1 with wb_src_o=2; pc wraps to 8'h00.
